// File: rtl/io_port_responder.sv
// Memory-mapped PortOut/PortIn responder for the MEM stage of the MIPS pipeline.
// Define IO_PORT_EDGE_FIFO_EN to build the PortIn change-event FIFO (STATUS/FIFO registers).
module io_port_responder #(
  parameter int unsigned      NBits      = 32,
  parameter logic [NBits-1:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned      FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBits-1:0] Address,
  input  logic [NBits-1:0] WriteData,
  input  logic [7:0]       PortIn,
  output logic             Hit,
  output logic [NBits-1:0] ReadData,
  output logic [NBits-1:0] PortOut
);

  logic [1:0] offset;
  logic [7:0] sync1, sync2;
  logic       writeOut;
  logic       unusedBits;

  assign Hit        = (Address[NBits-1:4] == BASE_ADDR[NBits-1:4]);
  assign offset     = Address[3:2];
  assign writeOut   = MemWrite & Hit & (offset == 2'd0);
  assign unusedBits = ^{MemRead, Address[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut <= '0;
      sync1   <= '0;
      sync2   <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      if (writeOut) PortOut <= WriteData;
    end
  end

`ifdef IO_PORT_EDGE_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]      prev;
  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] rdPtr, wrPtr;
  logic [CntW-1:0] count;
  logic            ovf, empty, full;
  logic            push, popReq, pop, pushOk, drop, ovfClr;
  logic [7:0]      statusByte;

  assign empty  = (count == '0);
  assign full   = (count == CntW'(FIFO_DEPTH));
  assign push   = (sync2 != prev);
  // A simultaneous store suppresses the load's pop side effect.
  assign popReq = MemRead & ~MemWrite & Hit & (offset == 2'd3);
  assign pop    = popReq & ~empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign pushOk = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign ovfClr = MemWrite & Hit & (offset == 2'd2) & WriteData[2];

  assign statusByte = {1'b0, 3'(count), 1'b0, ovf, full, ~empty};

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= sync2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      prev <= sync2;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)        ovf <= 1'b1;
      else if (ovfClr) ovf <= 1'b0;
    end
  end
`endif

  always_comb begin
    ReadData = '0;
    if (Hit) begin
      case (offset)
        2'd0:    ReadData = PortOut;
        2'd1:    ReadData = NBits'(sync2);
`ifdef IO_PORT_EDGE_FIFO_EN
        2'd2:    ReadData = NBits'(statusByte);
        2'd3:    ReadData = empty ? '0 : NBits'(fifoMem[rdPtr]);
`endif
        default: ReadData = '0;
      endcase
    end
  end

endmodule
